uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between NUM_REQ byte-stream requesters.
//  Grants are round-robin. A grant is locked per packet: it holds until the granted
//  requester's byte flagged last has been fully transmitted.
//  Sits between the application sources and uart_tx: drives its start pulse and byte, and watches its busy flag.
// PARAMETERS
//  NUM_REQ        4       number of requesters, 2..8
//  ID_W           2       grant index width, $clog2(NUM_REQ)
//  TIMEOUT_CYCLES 100000  max idle cycles in HOLD before lock release (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk           in   1          system clock, single clock domain
//  rst_n         in   1          asynchronous active-low reset
//  req_valid     in   NUM_REQ    requester i has a byte; held high until req_ready[i]
//  req_data      in   NUM_REQ*8  byte of requester i in bits [8i+7:8i]
//  req_last      in   NUM_REQ    byte of requester i ends its packet
//  req_ready     out  NUM_REQ    1-cycle accept pulse to the granted requester
//  tx_start      out  1          1-cycle start pulse to uart_tx
//  tx_data       out  8          byte to uart_tx, stable from START until the next LOAD
//  tx_busy       in   1          uart_tx busy, high while a frame is on the line
//  grant_id      out  ID_W       index of the current/last granted requester
//  arb_active    out  1          high in every state except IDLE
//  timeout_flag  out  1          1-cycle pulse on lock timeout; constant 0 without the macro
// BEHAVIOUR
//  Reset values: state=IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=NUM_REQ-1,
//   arb_active=0, timeout_flag=0, last_r=0, hold counter=0.
//   The round-robin pointer resets so that requester 0 wins first.
//  Reset asserted mid-operation aborts immediately to IDLE, with no tx_start and no ready.
//   A frame already in uart_tx is not this block's concern.
//  FSM, with all outputs decoded from registered state:
//   IDLE      : any req_valid -> latch winner into grant_id -> LOAD.
//               Winner is the first valid index searching from grant_id+1, modulo NUM_REQ.
//   LOAD      : req_ready[grant_id]=1 for this cycle only.
//               tx_data<=req_data[grant_id]; last_r<=req_last[grant_id] -> START.
//   START     : tx_start=1 for exactly one cycle -> WAIT_BUSY.
//   WAIT_BUSY : tx_busy=1 -> WAIT_DONE.
//   WAIT_DONE : tx_busy=0 -> if last_r then IDLE, else HOLD.
//   HOLD      : req_valid[grant_id] -> LOAD. Other requesters are ignored (packet lock).
//  Latency: valid first sampled in IDLE at cycle n -> req_ready at n+1 -> tx_start at n+2.
//  Back-to-back bytes within a packet: WAIT_DONE exit -> HOLD (1 cycle) -> LOAD -> START.
//  Contention: simultaneous valids are resolved only in IDLE; losers keep valid high and wait.
//  Fairness: every requester with valid held high is granted within NUM_REQ packets.
//  Wrap-around: the search after index NUM_REQ-1 continues at 0.
//   grant_id is unchanged between packets when only the same requester is valid.
//  A requester dropping valid after its ready pulse is legal: the byte is already captured.
//  Valid dropping before its ready pulse is a protocol violation; behaviour is unspecified.
//  Bits of req_data/req_last for non-granted indices are don't-care.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//   - HOLD counts cycles, cleared on entering HOLD.
//   - At TIMEOUT_CYCLES-1: pulse timeout_flag, go to IDLE, and treat the packet as ended.
//   - The next arbitration starts after grant_id, so the stalled requester goes last.
//  UART_ARB_TIMEOUT_EN undefined:
//   - No counter; HOLD waits forever.
//   - timeout_flag is tied to 0.
// STRUCTURE
//  uart_pkg: FSM state localparams (IDLE..HOLD, 3-bit encoding) and a shared BYTE_W=8 constant.
//  Sub-module uart_rr_pick: combinational round-robin picker.
//   Inputs: req vector, last grant index. Outputs: winner index, any_req.
//   Instantiated once; the arbiter holds all state.
// TESTING
//  1 Single req0, 1-byte packet (0xA5, last=1): req_ready[0] at n+1, tx_start at n+2,
//    tx_data=0xA5; return to IDLE after tx_busy falls.
//  2 req0 and req2 valid together, 1-byte packets each: grant order 0 then 2.
//    Then req0 again with req2: grant goes to 0 only after 2 is served (rotation).
//  3 req1 sends 3-byte packet 0x11,0x22,0x33(last) while req3 stays valid:
//    req3 gets no ready until 0x33 has completed.
//  4 req3 then req0 both valid, starting from grant_id=3: winner is 0 (wrap).
//  5 Macro on, TIMEOUT_CYCLES=16: req1 non-last byte then valid low for 20 cycles:
//    timeout_flag pulses once, in cycle 16 of HOLD; pending req2 is granted next.
//  6 rst_n asserted during WAIT_DONE: all outputs at reset values immediately.
//    After release, a pending req0 is served normally with no tx_start glitch.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: arbiter FSM state encoding and shared byte width
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    HOLD      = 3'd5
  } state_t;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first set req after last (ports: req, last -> win, any_req)
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    win,
  output logic               any_req
);
  int idx;
  // Scan from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    win = last;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx[ID_W-1:0]]) win = idx[ID_W-1:0];
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx among NUM_REQ requesters
//   clk, rst_n (async, active-low); req_valid/req_data/req_last in, req_ready out (per requester);
//   tx_start/tx_data out, tx_busy in (uart_tx side); grant_id, arb_active, timeout_flag status.
//   Optional macro UART_ARB_TIMEOUT_EN: releases a stalled packet lock after TIMEOUT_CYCLES in HOLD.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      arb_active,
  output logic                      timeout_flag
);
  state_t          state, state_n;
  logic            last_r;
  logic [ID_W-1:0] win;
  logic            any_req;
  logic            hold_to;

  uart_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_valid),
    .last   (grant_id),
    .win    (win),
    .any_req(any_req)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] hold_cnt;
  // Counter sits at zero outside HOLD, so it is clear on every HOLD entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= (state == HOLD) ? hold_cnt + CNT_W'(1) : '0;
  end
  assign hold_to = (state == HOLD) && (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign hold_to        = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = any_req ? LOAD : IDLE;
      LOAD:      state_n = START;
      START:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_n = tx_busy ? WAIT_DONE : (last_r ? IDLE : HOLD);
      HOLD:      state_n = hold_to ? IDLE : (req_valid[grant_id] ? LOAD : HOLD);
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= ID_W'(NUM_REQ - 1);
      tx_data  <= '0;
      last_r   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) grant_id <= win;
      if (state == LOAD) begin
        tx_data <= req_data[BYTE_W*grant_id +: BYTE_W];
        last_r  <= req_last[grant_id];
      end
    end
  end

  assign req_ready    = (state == LOAD) ? NUM_REQ'(1) << grant_id : '0;
  assign tx_start     = (state == START);
  assign arb_active   = (state != IDLE);
  assign timeout_flag = hold_to;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checking of uart_tx_arbiter against a packet-level model
module tb_uart_tx_arbiter;
  logic        clk, rst_n;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        tx_start, tx_busy, arb_active, timeout_flag;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_active(arb_active), .timeout_flag(timeout_flag)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int vectors = 0, errors = 0;
  logic [8:0] q [4][$];
  int hold_off [4];
  int glog[$];
  logic [7:0] txlog[$];
  int owner, last_g, gap_max, ut, u_dly, u_len, pushed;
  bit start_due, to_ok, busy_fell;
  logic [7:0] exp_byte;
  logic [3:0] rdy_prev, prev_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic push(input int i, input logic last, input logic [7:0] d);
    q[i].push_back({last, d});
    pushed++;
  endtask

  task automatic model_reset();
    owner = -1; last_g = 3; start_due = 0; rdy_prev = 0;
    for (int i = 0; i < 4; i++) hold_off[i] = 0;
  endtask

  task automatic monitor();
    int idx, exp;
    logic [8:0] head;
    if (!rst_n) begin
      start_due = 0; rdy_prev = 0;
      return;
    end
    if (tx_start || start_due) begin
      check("start", tx_start, start_due);
      if (tx_start) begin
        check("tx_data", tx_data, exp_byte);
        check("active", arb_active, 1);
        txlog.push_back(tx_data);
      end
    end
    start_due = 0;
    if (ut > 0 && req_ready != 0) check("rdy_in_frame", req_ready, 0);
    if (timeout_flag && !to_ok) check("to_spurious", timeout_flag, 0);
    if (timeout_flag) owner = -1;
    if (req_ready != 0) begin
      idx = 0;
      for (int i = 3; i >= 0; i--) if (req_ready[i]) idx = i;
      check("rdy_onehot", $countones(req_ready), 1);
      check("rdy_valid", prev_valid[idx], 1);
      exp = (owner >= 0) ? owner : rr(prev_valid, last_g);
      check("grant", idx, exp);
      check("grant_id", grant_id, idx);
      if (owner < 0) glog.push_back(idx);
      owner = idx; last_g = idx;
      if (q[idx].size() > 0) begin
        head = q[idx][0];
        exp_byte = head[7:0];
        start_due = 1;
        if (head[8]) owner = -1;
      end else check("rdy_no_data", q[idx].size(), 1);
    end
    rdy_prev = req_ready;
  endtask

  task automatic uart_update();
    bit nb;
    if (!rst_n) begin
      ut = 0; tx_busy = 0;
      return;
    end
    if (ut > 0) ut++;
    if (tx_start && ut == 0) begin
      ut = 1; u_dly = $urandom_range(1, 3); u_len = $urandom_range(2, 5);
    end
    nb = ut > u_dly && ut <= u_dly + u_len;
    if (tx_busy && !nb) busy_fell = 1;
    tx_busy = nb;
    if (ut > u_dly + u_len) ut = 0;
  endtask

  task automatic step();
    logic [8:0] h;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rdy_prev[i] && q[i].size() > 0) begin
        void'(q[i].pop_front());
        hold_off[i] = $urandom_range(0, gap_max);
      end else if (hold_off[i] > 0) hold_off[i]--;
    end
    monitor();
    uart_update();
    for (int i = 0; i < 4; i++) begin
      h = (q[i].size() > 0) ? q[i][0] : 9'h0;
      req_valid[i] = q[i].size() > 0 && hold_off[i] == 0;
      req_last[i] = h[8];
      req_data[8*i +: 8] = h[7:0];
    end
    prev_valid = req_valid;
  endtask

  function automatic bit pending();
    for (int i = 0; i < 4; i++) if (q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic run_until_idle(input string tag, input int max);
    int k = 0;
    while ((pending() || arb_active || ut != 0) && k < max) begin
      step();
      k++;
    end
    check({tag, "_drain"}, k < max, 1);
  endtask

  task automatic wait_fall(input string tag);
    int k = 0;
    busy_fell = 0;
    while (!busy_fell && k < 60) begin
      step();
      k++;
    end
    check({tag, "_busyfall"}, busy_fell, 1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_rdy"}, req_ready, 0);
    check({tag, "_start"}, tx_start, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_gid"}, grant_id, 3);
    check({tag, "_act"}, arb_active, 0);
    check({tag, "_to"}, timeout_flag, 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 0;
    #1;
    chk_reset(tag);
    model_reset();
    repeat (2) step();
    rst_n = 1;
  endtask

  int first_j, pulses, k;

  initial begin
    rst_n = 0; req_valid = 0; req_last = 0; req_data = 0; tx_busy = 0;
    ut = 0; u_dly = 1; u_len = 2; pushed = 0; gap_max = 0; to_ok = 0; busy_fell = 0;
    prev_valid = 0; exp_byte = 0;
    model_reset();
    repeat (3) step();
    chk_reset("rst");
    rst_n = 1;
    step();
    chk_reset("post");

    push(0, 1, 8'hA5);
    step();
    check("t1_rdy_n", req_ready, 0);
    step();
    check("t1_rdy", req_ready, 4'b0001);
    step();
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'hA5);
    wait_fall("t1");
    step();
    check("t1_idle", arb_active, 0);

    apply_reset("t2rst");
    glog.delete();
    push(0, 1, 8'h01); push(2, 1, 8'h02);
    run_until_idle("t2a", 200);
    push(0, 1, 8'h03); push(2, 1, 8'h04);
    run_until_idle("t2b", 200);
    check("t2_n", glog.size(), 4);
    if (glog.size() == 4) begin
      check("t2_g0", glog[0], 0); check("t2_g1", glog[1], 2);
      check("t2_g2", glog[2], 0); check("t2_g3", glog[3], 2);
    end

    glog.delete(); txlog.delete();
    push(1, 0, 8'h11); push(1, 0, 8'h22); push(1, 1, 8'h33);
    step(); step();
    push(3, 1, 8'h3C);
    run_until_idle("t3", 300);
    check("t3_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t3_g0", glog[0], 1); check("t3_g1", glog[1], 3);
    end
    check("t3_tn", txlog.size(), 4);
    if (txlog.size() == 4) begin
      check("t3_b0", txlog[0], 8'h11); check("t3_b1", txlog[1], 8'h22);
      check("t3_b2", txlog[2], 8'h33); check("t3_b3", txlog[3], 8'h3C);
    end

    glog.delete();
    push(3, 1, 8'h4D); push(0, 1, 8'h0E);
    run_until_idle("t4", 200);
    check("t4_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t4_g0", glog[0], 0); check("t4_g1", glog[1], 3);
    end

    glog.delete(); txlog.delete();
    push(1, 0, 8'h44); push(2, 1, 8'h55);
`ifdef UART_ARB_TIMEOUT_EN
    to_ok = 1;
    wait_fall("t5");
    first_j = 0; pulses = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (timeout_flag) begin
        pulses++;
        if (first_j == 0) first_j = j;
      end
    end
    check("t5_pos", first_j, 16);
    check("t5_cnt", pulses, 1);
    run_until_idle("t5", 200);
    to_ok = 0;
    check("t5_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t5_g0", glog[0], 1); check("t5_g1", glog[1], 2);
    end
`else
    wait_fall("t5");
    k = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (req_ready != 0 || timeout_flag) k++;
    end
    check("t5_lock", k, 0);
    check("t5_held", arb_active, 1);
    push(1, 1, 8'h45);
    run_until_idle("t5", 200);
    check("t5_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("t5_g0", glog[0], 1); check("t5_g1", glog[1], 2);
    end
    check("t5_tn", txlog.size(), 3);
    if (txlog.size() == 3) check("t5_b1", txlog[1], 8'h45);
`endif

    push(0, 1, 8'h66);
    k = 0;
    while (!tx_busy && k < 40) begin
      step();
      k++;
    end
    check("t6_busy", tx_busy, 1);
    step();
    check("t6_pre", arb_active, 1);
    rst_n = 0;
    #1;
    chk_reset("t6");
    model_reset();
    push(0, 1, 8'h77);
    repeat (2) step();
    rst_n = 1;
    glog.delete(); txlog.delete();
    run_until_idle("t6", 200);
    check("t6_n", txlog.size(), 1);
    if (txlog.size() == 1) check("t6_b", txlog[0], 8'h77);
    if (glog.size() == 1) check("t6_g", glog[0], 0);

    gap_max = 3;
    txlog.delete();
    pushed = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int r = $urandom_range(0, 3);
        int n = $urandom_range(1, 4);
        if (q[r].size() < 8)
          for (int b = 0; b < n; b++) push(r, b == n - 1, 8'($urandom));
      end
      step();
    end
    run_until_idle("rand", 5000);
    check("rand_bytes", txlog.size(), pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
